crc_stream: RTL
===============

Name: crc_stream

Overview:
- Parametrised streaming CRC engine with valid/ready handshakes on input and output.
- Generalises the fixed 32-bit dibit CRC to any data width, polynomial and seed.
- Two per-frame modes:
  - GEN: passes the payload through, then appends the FCS beats.
  - CHK: passes the received frame through and flags the FCS as good or bad.
- Sits between the MAC framing logic and the RMII dibit / byte datapaths.

Parameters:
- DATA_W, 2: bits per beat; one of 1, 2, 4, 8, 16, 32; must divide CRC_W.
- CRC_W, 32: CRC register width.
- POLY, 32'hEDB88320: reflected polynomial. The engine is LSB-first throughout.
- INIT, 32'hFFFFFFFF: register seed at frame start.
- XOROUT, 32'hFFFFFFFF: mask XORed onto the register to form the FCS.
- RESIDUE, 32'hDEBB20E3: register value after a good frame including its FCS (CHK mode).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- mode, in, 1: 0 = GEN, 1 = CHK. Sampled on the first beat of each frame.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: engine accepts the input beat.
- in_data, in, DATA_W: payload; bit 0 is earliest on the wire.
- in_last, in, 1: marks the final input beat of a frame.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts the output beat.
- out_data, out, DATA_W: payload or FCS beat.
- out_last, out, 1: final output beat of a frame.
- chk_done, out, 1: one-cycle pulse when a CHK frame completes.
- chk_ok, out, 1: FCS result; valid while chk_done is high.

Behaviour:
- Reset values: state=IDLE, crc=INIT, out_valid=0, out_last=0, chk_done=0, chk_ok=0, beat counter=0. in_ready=0 is forced during reset.
- Transfer rule: a beat transfers when valid && ready. Data, last and mode are held stable while valid=1 and ready=0.
- Per transferred input beat, the CRC performs DATA_W serial steps, bit 0 first, in a single clock:
  - c = {0, c[CRC_W-1:1]} ^ ((c[0] ^ d[i]) ? POLY : 0)
- States:
  - IDLE: waits for a frame.
  - DATA: payload flowing.
  - APPEND: emitting FCS beats.
- DATA path (IDLE/DATA) is a zero-latency pass-through:
  - out_valid=in_valid, out_data=in_data, in_ready=out_ready.
  - GEN: out_last=0. CHK: out_last=in_last.
- First transferred beat in IDLE:
  - latches mode; the mode input is ignored for the rest of the frame;
  - uses INIT as the CRC starting value;
  - moves to DATA, or handles last immediately for a single-beat frame.
- Last transfer in GEN:
  - latches fcs = final_crc ^ XOROUT;
  - goes to APPEND with counter=0.
- APPEND:
  - in_ready=0, out_valid=1, out_data=fcs[counter*DATA_W +: DATA_W].
  - counter increments on each output transfer.
  - out_last=1 on beat CRC_W/DATA_W-1; that transfer returns to IDLE with crc=INIT.
  - Example: DATA_W=2 gives 16 FCS beats.
- Last transfer in CHK:
  - on the next cycle, chk_done=1 for one cycle and chk_ok=(final_crc==RESIDUE);
  - state returns to IDLE.
- Back-to-back frames:
  - CHK: a new frame may start on the cycle after last.
  - GEN: a new frame may start on the cycle after the final FCS beat.
- Backpressure in APPEND: out_ready=0 holds the current beat and counter unchanged.
- Reset mid-frame or mid-APPEND: the frame is aborted; no remaining FCS beats or chk_done are emitted. in_valid is ignored on the reset cycle.
- No widths are truncated; the counter is $clog2(CRC_W/DATA_W) bits, minimum 1.

Optional Feature:
- Macro CRC_STATS_EN.
- When defined, adds outputs good_cnt[15:0] and bad_cnt[15:0]:
  - incremented on chk_done with chk_ok=1 or chk_ok=0 respectively;
  - saturate at 16'hFFFF;
  - reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- GEN, DATA_W=8, ASCII "123456789" (0x31..0x39) with last on 0x39, out_ready=1 -> the 9 payload beats pass through unchanged, then FCS 26 39 F4 CB with out_last on CB (CRC 0xCBF43926).
- CHK, DATA_W=8, "123456789" followed by 26 39 F4 CB, last on CB -> chk_done pulses one cycle after CB, chk_ok=1. Repeat with CB changed to CA -> chk_ok=0.
- GEN, DATA_W=2, single byte 0x00 sent as 4 dibits -> 16 FCS dibits forming 0xD202EF8D LSB-first, out_last on the 16th; in_ready=0 throughout APPEND.
- GEN backpressure: drop out_ready for 3 cycles on FCS beat 1 -> out_data holds 0x39 and the counter stays put; the sequence completes normally once out_ready returns high.
- Reset asserted on FCS beat 2, then a new CHK frame -> no further FCS or out_last; the new frame is checked from INIT and chk_ok matches the golden result.
- With CRC_STATS_EN: 2 good and 1 bad CHK frames -> good_cnt=2, bad_cnt=1.

Source files
------------

// File: rtl/crc_stream.sv
// Streaming LSB-first CRC engine: GEN appends the FCS after the payload, CHK flags the FCS as good or bad.
// Optional CRC_STATS_EN adds saturating good/bad frame counters (good_cnt, bad_cnt).
module crc_stream #(
  parameter int                DATA_W  = 2,
  parameter int                CRC_W   = 32,
  parameter logic [CRC_W-1:0]  POLY    = 32'hEDB88320,
  parameter logic [CRC_W-1:0]  INIT    = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0]  XOROUT  = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0]  RESIDUE = 32'hDEBB20E3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              chk_done,
  output logic              chk_ok,
`ifdef CRC_STATS_EN
  output logic [15:0]       good_cnt,
  output logic [15:0]       bad_cnt,
`endif
  output logic [1:0]        dbg_state
);

  localparam int NBEATS = CRC_W / DATA_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_APPEND = 2'd2
  } state_t;

  state_t           state;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] fcs;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;

  logic             cur_mode;
  logic [CRC_W-1:0] crc_base;
  logic [CRC_W-1:0] crc_next;
  logic             in_xfer;
  logic             out_xfer;

  // DATA_W serial LFSR steps, bit 0 first, unrolled into one cycle.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    c = c_in;
    for (int i = 0; i < DATA_W; i++) begin
      c = (c >> 1) ^ ((c[0] ^ d[i]) ? POLY : '0);
    end
    return c;
  endfunction

  // Handshake: a beat moves on any cycle where valid && ready; the sender
  // keeps data, last and mode stable while valid is high and ready is low.
  always_comb begin
    cur_mode  = (state == ST_IDLE) ? mode : mode_q;
    crc_base  = (state == ST_IDLE) ? INIT : crc;
    crc_next  = crc_step(crc_base, in_data);
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = in_data;
    out_last  = 1'b0;
    if (!reset) begin
      if (state == ST_APPEND) begin
        out_valid = 1'b1;
        out_data  = fcs[DATA_W-1:0];
        out_last  = (cnt == LAST_CNT);
      end else begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_last  = cur_mode & in_last;
      end
    end
  end

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign dbg_state = state;

  // fcs is shifted down one beat per output transfer, so its low bits are
  // always the beat selected by cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      crc      <= INIT;
      fcs      <= '0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      chk_done <= 1'b0;
      chk_ok   <= 1'b0;
    end else begin
      chk_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DATA: begin
          if (in_xfer) begin
            mode_q <= cur_mode;
            if (in_last) begin
              crc <= INIT;
              if (cur_mode) begin
                chk_done <= 1'b1;
                chk_ok   <= (crc_next == RESIDUE);
                state    <= ST_IDLE;
              end else begin
                fcs   <= crc_next ^ XOROUT;
                cnt   <= '0;
                state <= ST_APPEND;
              end
            end else begin
              crc   <= crc_next;
              state <= ST_DATA;
            end
          end
        end
        ST_APPEND: begin
          if (out_xfer) begin
            fcs <= fcs >> DATA_W;
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              crc   <= INIT;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CRC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (chk_done) begin
      if (chk_ok) begin
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      end else begin
        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
